// File: rtl/calc_op_sequencer.sv
// Operand/control stage feeding the SOMA and SUBTRACAO units: one request in flight.
// Optional carry/zero flag outputs are enabled by defining CALC_FLAGS_EN.
module calc_op_sequencer #(
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             op_in,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             en_soma,
    output logic             en_sub,
    input  logic [WIDTH-1:0] S_soma,
    input  logic [WIDTH-1:0] S_sub,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
`ifdef CALC_FLAGS_EN
    output logic             carry,
    output logic             zero,
`endif
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       count_reg, count_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             op_reg, op_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] captured;
    logic             last_exec;

    // Final EXEC cycle: the unit output is sampled on this edge.
    assign last_exec = (count_reg == 4'(EXEC_CYCLES - 1));
    assign captured  = op_reg ? S_sub : S_soma;

`ifdef CALC_FLAGS_EN
    logic             carry_reg, carry_next;
    logic             zero_reg, zero_next;
    logic [WIDTH:0]   wide_sum;

    assign wide_sum = {1'b0, a_reg} + {1'b0, b_reg};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= 1'b0;
            result_reg <= '0;
`ifdef CALC_FLAGS_EN
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            result_reg <= result_next;
`ifdef CALC_FLAGS_EN
            carry_reg  <= carry_next;
            zero_reg   <= zero_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        op_next     = op_reg;
        result_next = result_reg;
`ifdef CALC_FLAGS_EN
        carry_next  = carry_reg;
        zero_next   = zero_reg;
`endif
        in_ready    = 1'b0;
        en_soma     = 1'b0;
        en_sub      = 1'b0;
        out_valid   = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_next     = A_in;
                    b_next     = B_in;
                    op_next    = op_in;
                    count_next = '0;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Enables decode only from registered state so they never glitch.
                en_soma    = ~op_reg;
                en_sub     = op_reg;
                count_next = count_reg + 4'd1;
                if (last_exec) begin
                    result_next = captured;
`ifdef CALC_FLAGS_EN
                    carry_next  = op_reg ? (a_reg < b_reg) : wide_sum[WIDTH];
                    zero_next   = (captured == '0);
`endif
                    state_next  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign A      = a_reg;
    assign B      = b_reg;
    assign result = result_reg;
`ifdef CALC_FLAGS_EN
    assign carry  = carry_reg;
    assign zero   = zero_reg;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_calc_op_sequencer;
    localparam int W  = 8;
    localparam int EC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A_in, B_in;
    logic         op_in;
    logic [W-1:0] A, B;
    logic         en_soma, en_sub;
    logic [W-1:0] S_soma, S_sub;
    logic [W-1:0] result;
    logic         out_valid;
    logic         out_ready;
`ifdef CALC_FLAGS_EN
    logic         carry, zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural stand-ins for the SOMA and SUBTRACAO units.
    assign S_soma = A + B;
    assign S_sub  = A - B;

    calc_op_sequencer #(.WIDTH(W), .EXEC_CYCLES(EC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_in(A_in), .B_in(B_in), .op_in(op_in),
        .A(A), .B(B), .en_soma(en_soma), .en_sub(en_sub),
        .S_soma(S_soma), .S_sub(S_sub),
        .result(result), .out_valid(out_valid),
`ifdef CALC_FLAGS_EN
        .carry(carry), .zero(zero),
`endif
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_result(input int a, input int b, input bit op);
        return op ? ((a - b + 256) % 256) : ((a + b) % 256);
    endfunction

    function automatic int ref_carry(input int a, input int b, input bit op);
        return op ? int'(a < b) : int'((a + b) > 255);
    endfunction

    // Full handshake for one operation, holding off out_ready for 'hold' cycles.
    task automatic run_op(input int a, input int b, input bit op, input int hold);
        int exp;
        exp = ref_result(a, b, op);
        in_valid = 1'b1; A_in = W'(a); B_in = W'(b); op_in = op; out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < EC; i++) begin
            chk("exec_en_soma", en_soma, int'(!op));
            chk("exec_en_sub", en_sub, int'(op));
            chk("exec_out_valid", out_valid, 0);
            chk("exec_in_ready", in_ready, 0);
            chk("exec_A", A, a);
            tick();
        end
        chk("done_out_valid", out_valid, 1);
        chk("done_result", result, exp);
        chk("done_en_soma", en_soma, 0);
        chk("done_en_sub", en_sub, 0);
        chk("done_B", B, b);
`ifdef CALC_FLAGS_EN
        chk("done_carry", carry, ref_carry(a, b, op));
        chk("done_zero", zero, int'(exp == 0));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; A_in = W'(a + 1); B_in = W'(b + 3); op_in = ~op;
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_result", result, exp);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ack_out_valid", out_valid, 0);
        chk("ack_in_ready", in_ready, 1);
        chk("ack_A_held", A, a);
        $display("op a=%0d b=%0d sub=%0d hold=%0d result=%0d expected=%0d", a, b, op, hold, result, exp);
    endtask

    initial begin
        int a_v[3], b_v[3];
        bit op_v[3];
        int exp_q[$];
        int cyc, last_acc, accepted, got;
        bit acc, outh;

        rst_n = 1'b0; in_valid = 1'b0; A_in = '0; B_in = '0; op_in = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_A", A, 0);
        chk("rst_result", result, 0);
        chk("rst_en", {en_soma, en_sub}, 0);

        run_op(100, 27, 1'b0, 0);
        run_op(200, 100, 1'b0, 0);
        run_op(5, 7, 1'b1, 0);
        run_op(9, 9, 1'b1, 0);
        run_op(77, 33, 1'b1, 10);

        // Reset in the middle of EXEC aborts the operation.
        in_valid = 1'b1; A_in = 8'd50; B_in = 8'd60; op_in = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_A", A, 0);
        chk("mid_rst_B", B, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_en", {en_soma, en_sub}, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        for (int i = 0; i < EC + 2; i++) begin
            tick();
            chk("mid_rst_no_valid", out_valid, 0);
        end
        $display("reset mid-EXEC: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        run_op(12, 34, 1'b0, 1);

        // Back-to-back requests with in_valid held continuously.
        for (int i = 0; i < 3; i++) begin
            a_v[i] = int'($urandom_range(0, 255));
            b_v[i] = int'($urandom_range(0, 255));
            op_v[i] = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b1; out_ready = 1'b1;
        A_in = W'(a_v[0]); B_in = W'(b_v[0]); op_in = op_v[0];
        cyc = 0; last_acc = -1; accepted = 0; got = 0;
        while (got < 3 && cyc < 200) begin
            acc  = in_valid && in_ready;
            outh = out_valid && out_ready;
            if (outh) begin
                if (exp_q.size() > 0) begin
                    chk("b2b_result", result, exp_q[0]);
                    $display("b2b result=%0d expected=%0d", result, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    chk("b2b_unexpected_valid", out_valid, 0);
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, EC + 2);
                last_acc = cyc;
                exp_q.push_back(ref_result(a_v[accepted], b_v[accepted], op_v[accepted]));
                accepted++;
                if (accepted < 3) begin
                    A_in = W'(a_v[accepted]); B_in = W'(b_v[accepted]); op_in = op_v[accepted];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", got, 3);
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // Randomized operations with random back-pressure.
        for (int i = 0; i < 20; i++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
